// File: rtl/bsg_fifo_1rw_sched_pkg.sv
// Shared types and width helpers for the 1RW-SRAM FIFO scheduler.
package bsg_fifo_1rw_sched_pkg;

  typedef enum logic [1:0] {
    GNT_IDLE = 2'd0,
    GNT_WR   = 2'd1,
    GNT_RD   = 2'd2
  } grant_e;

  // A one-entry RAM still needs a one-bit address.
  function automatic int addr_w_f(input int els);
    return (els > 1) ? $clog2(els) : 1;
  endfunction

  function automatic int cnt_w_f(input int els);
    return $clog2(els + 1);
  endfunction

endpackage

// File: rtl/bsg_fifo_1rw_sched_if.sv
// Producer/consumer handshakes and RAM command bundle for bsg_fifo_1rw_sched.
// Handshake: *_v_i says the requester is ready this cycle; *_yumi_o is the same-cycle
// grant, and a request is consumed exactly in the cycles where both are high.
interface bsg_fifo_1rw_sched_if
  import bsg_fifo_1rw_sched_pkg::*;
#(
  parameter int els_p = 64
);
  localparam int addr_w = addr_w_f(els_p);
  localparam int cnt_w  = cnt_w_f(els_p);

  logic              enq_v_i;
  logic              enq_yumi_o;
  logic              deq_v_i;
  logic              deq_yumi_o;
  logic              rdata_v_o;
  logic              mem_v_o;
  logic              mem_w_o;
  logic [addr_w-1:0] mem_addr_o;
  logic              full_o;
  logic              empty_o;
  logic [cnt_w-1:0]  count_o;
  grant_e            gnt_dbg_o;

  modport slave (
    input  enq_v_i, deq_v_i,
    output enq_yumi_o, deq_yumi_o, rdata_v_o, mem_v_o, mem_w_o, mem_addr_o,
           full_o, empty_o, count_o, gnt_dbg_o
  );

  modport master (
    output enq_v_i, deq_v_i,
    input  enq_yumi_o, deq_yumi_o, rdata_v_o, mem_v_o, mem_w_o, mem_addr_o,
           full_o, empty_o, count_o, gnt_dbg_o
  );

endinterface

// File: rtl/bsg_fifo_1rw_sched_ptr.sv
// Wrapping FIFO pointer: advances on inc_i, wraps els_p-1 -> 0 for any depth.
module bsg_fifo_1rw_sched_ptr #(
  parameter int els_p  = 64,
  parameter int addr_w = 6
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              inc_i,
  output logic [addr_w-1:0] ptr_o
);

  localparam logic [addr_w-1:0] last_lp = addr_w'(els_p - 1);

  logic [addr_w-1:0] ptr_d, ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (inc_i) begin
      ptr_d = (ptr_q == last_lp) ? '0 : ptr_q + addr_w'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/bsg_fifo_1rw_sched.sv
// Single-port-RAM FIFO scheduler: write priority with a bounded read-starvation limit.
// Optional BSG_FIFO_1RW_SCHED_STATS_EN adds conflict / forced-read statistics counters.
module bsg_fifo_1rw_sched
  import bsg_fifo_1rw_sched_pkg::*;
#(
  parameter int els_p          = 64,
  parameter int starve_limit_p = 4
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  bsg_fifo_1rw_sched_if.slave         io
`ifdef BSG_FIFO_1RW_SCHED_STATS_EN
  ,
  output logic [31:0]                 conflict_cnt_o,
  output logic [31:0]                 forced_rd_cnt_o
`endif
);

  localparam int addr_w   = addr_w_f(els_p);
  localparam int cnt_w    = cnt_w_f(els_p);
  localparam int starve_w = cnt_w_f(starve_limit_p);

  localparam logic [cnt_w-1:0]    full_cnt_lp   = cnt_w'(els_p);
  localparam logic [starve_w-1:0] starve_max_lp = starve_w'(starve_limit_p);

  logic [cnt_w-1:0]    count_d, count_q;
  logic [starve_w-1:0] starve_d, starve_q;
  logic                rdata_v_d, rdata_v_q;
  logic [addr_w-1:0]   head, tail;
  logic                full, empty;
  logic                wr_ok, rd_ok, conflict;
  grant_e              gnt;

  assign full  = (count_q == full_cnt_lp);
  assign empty = (count_q == '0);

  // Reset gates eligibility so no grant leaks out while reset_i is held.
  assign wr_ok    = io.enq_v_i & ~full  & ~reset_i;
  assign rd_ok    = io.deq_v_i & ~empty & ~reset_i;
  assign conflict = wr_ok & rd_ok;

  always_comb begin
    gnt = GNT_IDLE;
    if (conflict) begin
      gnt = (starve_q == starve_max_lp) ? GNT_RD : GNT_WR;
    end else if (wr_ok) begin
      gnt = GNT_WR;
    end else if (rd_ok) begin
      gnt = GNT_RD;
    end
  end

  // Starvation only accrues while a read is eligible and loses to a write.
  always_comb begin
    starve_d = starve_q;
    if (!rd_ok || gnt == GNT_RD) begin
      starve_d = '0;
    end else if (gnt == GNT_WR && starve_q != starve_max_lp) begin
      starve_d = starve_q + starve_w'(1);
    end
  end

  always_comb begin
    count_d = count_q;
    if (gnt == GNT_WR) count_d = count_q + cnt_w'(1);
    if (gnt == GNT_RD) count_d = count_q - cnt_w'(1);
  end

  assign rdata_v_d = (gnt == GNT_RD);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count_q   <= '0;
      starve_q  <= '0;
      rdata_v_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      starve_q  <= starve_d;
      rdata_v_q <= rdata_v_d;
    end
  end

  bsg_fifo_1rw_sched_ptr #(
    .els_p  (els_p),
    .addr_w (addr_w)
  ) head_ptr (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .inc_i   (gnt == GNT_RD),
    .ptr_o   (head)
  );

  bsg_fifo_1rw_sched_ptr #(
    .els_p  (els_p),
    .addr_w (addr_w)
  ) tail_ptr (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .inc_i   (gnt == GNT_WR),
    .ptr_o   (tail)
  );

  assign io.enq_yumi_o = (gnt == GNT_WR);
  assign io.deq_yumi_o = (gnt == GNT_RD);
  assign io.mem_v_o    = (gnt != GNT_IDLE);
  assign io.mem_w_o    = (gnt == GNT_WR);
  assign io.mem_addr_o = (gnt == GNT_RD) ? head : tail;
  assign io.rdata_v_o  = rdata_v_q;
  assign io.full_o     = full;
  assign io.empty_o    = empty;
  assign io.count_o    = count_q;
  assign io.gnt_dbg_o  = gnt;

`ifdef BSG_FIFO_1RW_SCHED_STATS_EN
  logic [31:0] conflict_cnt_d, conflict_cnt_q;
  logic [31:0] forced_rd_cnt_d, forced_rd_cnt_q;

  // A read that wins a conflict can only have been forced by the starve limit.
  always_comb begin
    conflict_cnt_d  = conflict_cnt_q;
    forced_rd_cnt_d = forced_rd_cnt_q;
    if (conflict && conflict_cnt_q != '1) begin
      conflict_cnt_d = conflict_cnt_q + 32'd1;
    end
    if (conflict && gnt == GNT_RD && forced_rd_cnt_q != '1) begin
      forced_rd_cnt_d = forced_rd_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      conflict_cnt_q  <= '0;
      forced_rd_cnt_q <= '0;
    end else begin
      conflict_cnt_q  <= conflict_cnt_d;
      forced_rd_cnt_q <= forced_rd_cnt_d;
    end
  end

  assign conflict_cnt_o  = conflict_cnt_q;
  assign forced_rd_cnt_o = forced_rd_cnt_q;
`endif

endmodule

// File: tb/tb_bsg_fifo_1rw_sched.sv
// Directed vectors plus scoreboarded random traffic for bsg_fifo_1rw_sched.
module tb_bsg_fifo_1rw_sched;

  logic clk;
  logic reset;

  int checks;
  int errors;

  // Instance A: depth 5 (non power of two); instance B: depth 16 for the starvation pattern.
  bsg_fifo_1rw_sched_if #(.els_p(5))  a_if ();
  bsg_fifo_1rw_sched_if #(.els_p(16)) b_if ();

`ifdef BSG_FIFO_1RW_SCHED_STATS_EN
  logic [31:0] a_conf, a_forced, b_conf, b_forced;
`endif

  bsg_fifo_1rw_sched #(.els_p(5), .starve_limit_p(4)) dut_a (
    .clk_i   (clk),
    .reset_i (reset),
    .io      (a_if)
`ifdef BSG_FIFO_1RW_SCHED_STATS_EN
    ,
    .conflict_cnt_o  (a_conf),
    .forced_rd_cnt_o (a_forced)
`endif
  );

  bsg_fifo_1rw_sched #(.els_p(16), .starve_limit_p(4)) dut_b (
    .clk_i   (clk),
    .reset_i (reset),
    .io      (b_if)
`ifdef BSG_FIFO_1RW_SCHED_STATS_EN
    ,
    .conflict_cnt_o  (b_conf),
    .forced_rd_cnt_o (b_forced)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       enq, deq;
    logic       ey, dy, mv, mw;
    logic [2:0] addr;
    logic [2:0] cnt;
    logic       full, empty, rdv;
  } vec_t;

  vec_t vecs[24];

  function automatic vec_t mk(input logic enq, deq, ey, dy, mv, mw,
                              input logic [2:0] addr, cnt,
                              input logic full, empty, rdv);
    vec_t v;
    v.enq = enq; v.deq = deq; v.ey = ey; v.dy = dy; v.mv = mv; v.mw = mw;
    v.addr = addr; v.cnt = cnt; v.full = full; v.empty = empty; v.rdv = rdv;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_a(input logic enq, input logic deq);
    @(negedge clk);
    a_if.enq_v_i = enq;
    a_if.deq_v_i = deq;
    #2;
  endtask

  task automatic drive_b(input logic enq, input logic deq);
    @(negedge clk);
    b_if.enq_v_i = enq;
    b_if.deq_v_i = deq;
    #2;
  endtask

  // ---------------- scoreboard state ----------------
  logic [15:0] exp_q[$];
  logic [15:0] ram[5];
  logic [15:0] wdata;
  logic [15:0] rd_hold;
  logic [15:0] exp_word;
  logic        prev_dy;
  int          model_cnt;

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    a_if.enq_v_i = 1'b0; a_if.deq_v_i = 1'b0;
    b_if.enq_v_i = 1'b0; b_if.deq_v_i = 1'b0;

    //        enq deq ey dy mv mw addr cnt full empty rdv
    vecs[0]  = mk(0, 0, 0, 0, 0, 0, 3'd0, 3'd0, 0, 1, 0);
    vecs[1]  = mk(1, 0, 1, 0, 1, 1, 3'd0, 3'd0, 0, 1, 0);
    vecs[2]  = mk(0, 1, 0, 1, 1, 0, 3'd0, 3'd1, 0, 0, 0);
    vecs[3]  = mk(0, 0, 0, 0, 0, 0, 3'd0, 3'd0, 0, 1, 1);
    vecs[4]  = mk(0, 1, 0, 0, 0, 0, 3'd0, 3'd0, 0, 1, 0);
    vecs[5]  = mk(1, 0, 1, 0, 1, 1, 3'd1, 3'd0, 0, 1, 0);
    vecs[6]  = mk(1, 0, 1, 0, 1, 1, 3'd2, 3'd1, 0, 0, 0);
    vecs[7]  = mk(1, 0, 1, 0, 1, 1, 3'd3, 3'd2, 0, 0, 0);
    vecs[8]  = mk(1, 0, 1, 0, 1, 1, 3'd4, 3'd3, 0, 0, 0);
    vecs[9]  = mk(1, 0, 1, 0, 1, 1, 3'd0, 3'd4, 0, 0, 0);
    vecs[10] = mk(1, 0, 0, 0, 0, 0, 3'd0, 3'd5, 1, 0, 0);
    vecs[11] = mk(1, 1, 0, 1, 1, 0, 3'd1, 3'd5, 1, 0, 0);
    vecs[12] = mk(0, 1, 0, 1, 1, 0, 3'd2, 3'd4, 0, 0, 1);
    vecs[13] = mk(0, 1, 0, 1, 1, 0, 3'd3, 3'd3, 0, 0, 1);
    vecs[14] = mk(0, 1, 0, 1, 1, 0, 3'd4, 3'd2, 0, 0, 1);
    vecs[15] = mk(0, 1, 0, 1, 1, 0, 3'd0, 3'd1, 0, 0, 1);
    vecs[16] = mk(0, 1, 0, 0, 0, 0, 3'd0, 3'd0, 0, 1, 1);
    vecs[17] = mk(1, 0, 1, 0, 1, 1, 3'd1, 3'd0, 0, 1, 0);
    vecs[18] = mk(1, 1, 1, 0, 1, 1, 3'd2, 3'd1, 0, 0, 0);
    vecs[19] = mk(1, 1, 1, 0, 1, 1, 3'd3, 3'd2, 0, 0, 0);
    vecs[20] = mk(1, 1, 1, 0, 1, 1, 3'd4, 3'd3, 0, 0, 0);
    vecs[21] = mk(1, 1, 1, 0, 1, 1, 3'd0, 3'd4, 0, 0, 0);
    vecs[22] = mk(1, 1, 0, 1, 1, 0, 3'd1, 3'd5, 1, 0, 0);
    vecs[23] = mk(1, 1, 1, 0, 1, 1, 3'd1, 3'd4, 0, 0, 1);

    // Requests held during reset must not be granted.
    #3;
    a_if.enq_v_i = 1'b1;
    #1;
    check("rst_enq_yumi", 32'(a_if.enq_yumi_o), 32'd0);
    check("rst_mem_v",    32'(a_if.mem_v_o),    32'd0);
    check("rst_empty",    32'(a_if.empty_o),    32'd1);
    check("rst_full",     32'(a_if.full_o),     32'd0);
    check("rst_count",    32'(a_if.count_o),    32'd0);
    check("rst_rdv",      32'(a_if.rdata_v_o),  32'd0);
    a_if.enq_v_i = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    // ---------------- table-driven vectors on A ----------------
    for (int i = 0; i < 24; i++) begin
      drive_a(vecs[i].enq, vecs[i].deq);
      check($sformatf("vec%0d_enq_yumi", i), 32'(a_if.enq_yumi_o), 32'(vecs[i].ey));
      check($sformatf("vec%0d_deq_yumi", i), 32'(a_if.deq_yumi_o), 32'(vecs[i].dy));
      check($sformatf("vec%0d_mem_v", i),    32'(a_if.mem_v_o),    32'(vecs[i].mv));
      if (vecs[i].mv) begin
        check($sformatf("vec%0d_mem_w", i),    32'(a_if.mem_w_o),    32'(vecs[i].mw));
        check($sformatf("vec%0d_mem_addr", i), 32'(a_if.mem_addr_o), 32'(vecs[i].addr));
      end
      check($sformatf("vec%0d_count", i), 32'(a_if.count_o),   32'(vecs[i].cnt));
      check($sformatf("vec%0d_full", i),  32'(a_if.full_o),    32'(vecs[i].full));
      check($sformatf("vec%0d_empty", i), 32'(a_if.empty_o),   32'(vecs[i].empty));
      check($sformatf("vec%0d_rdv", i),   32'(a_if.rdata_v_o), 32'(vecs[i].rdv));
    end

    // ---------------- async reset with a read in flight ----------------
    drive_a(1'b1, 1'b1);
    check("midrst_read_gnt", 32'(a_if.deq_yumi_o), 32'd1);
    @(posedge clk);
    #1;
    check("midrst_rdv_before", 32'(a_if.rdata_v_o), 32'd1);
    check("midrst_count_before", 32'(a_if.count_o), 32'd4);
    #1;
    reset = 1'b1;
    #1;
    check("midrst_count", 32'(a_if.count_o),    32'd0);
    check("midrst_empty", 32'(a_if.empty_o),    32'd1);
    check("midrst_full",  32'(a_if.full_o),     32'd0);
    check("midrst_ey",    32'(a_if.enq_yumi_o), 32'd0);
    check("midrst_dy",    32'(a_if.deq_yumi_o), 32'd0);
    check("midrst_mem_v", 32'(a_if.mem_v_o),    32'd0);
    check("midrst_rdv",   32'(a_if.rdata_v_o),  32'd0);
    @(posedge clk);
    #1;
    check("midrst_rdv_edge", 32'(a_if.rdata_v_o), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    a_if.enq_v_i = 1'b0;
    a_if.deq_v_i = 1'b0;
    #2;
    check("postrst_count", 32'(a_if.count_o), 32'd0);
    check("postrst_empty", 32'(a_if.empty_o), 32'd1);

    // ---------------- starvation pattern on B: W W W W R repeating ----------------
    for (int c = 0; c <= 20; c++) begin
      drive_b(1'b1, 1'b1);
      check($sformatf("starve_c%0d_deq_yumi", c), 32'(b_if.deq_yumi_o),
            32'((c > 0) && (c % 5 == 0)));
      check($sformatf("starve_c%0d_enq_yumi", c), 32'(b_if.enq_yumi_o),
            32'(!((c > 0) && (c % 5 == 0))));
    end
    drive_b(1'b0, 1'b0);
    check("starve_count", 32'(b_if.count_o), 32'd13);
`ifdef BSG_FIFO_1RW_SCHED_STATS_EN
    check("stats_forced", b_forced, 32'd4);
    check("stats_conflict", b_conf, 32'd20);
`endif

    // ---------------- random traffic on A against the scoreboard ----------------
    wdata     = 16'h100;
    prev_dy   = 1'b0;
    model_cnt = 0;
    rd_hold   = '0;
    for (int k = 0; k < 5; k++) ram[k] = '0;
    for (int n = 0; n < 400; n++) begin
      drive_a(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      check("rnd_rdv", 32'(a_if.rdata_v_o), 32'(prev_dy));
      if (prev_dy && a_if.rdata_v_o) begin
        if (exp_q.size() == 0) begin
          check("rnd_sb_underflow", 32'(exp_q.size()), 32'd1);
        end else begin
          exp_word = exp_q.pop_front();
          check("rnd_order", 32'(rd_hold), 32'(exp_word));
        end
      end
      check("rnd_count", 32'(a_if.count_o), 32'(model_cnt));
      check("rnd_one_gnt", 32'(a_if.enq_yumi_o & a_if.deq_yumi_o), 32'd0);
      check("rnd_busy", 32'(a_if.enq_yumi_o | a_if.deq_yumi_o),
            32'((a_if.enq_v_i && model_cnt < 5) || (a_if.deq_v_i && model_cnt > 0)));
      if (a_if.enq_yumi_o) begin
        ram[a_if.mem_addr_o] = wdata;
        exp_q.push_back(wdata);
        wdata++;
        model_cnt++;
      end
      if (a_if.deq_yumi_o) begin
        rd_hold = ram[a_if.mem_addr_o];
        model_cnt--;
      end
      prev_dy = a_if.deq_yumi_o;
    end

    // ---------------- final report ----------------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
